// File: rtl/fuzz_top_pkg.sv
// Shared widths, y field offsets and payload structs for the fuzz_top mixing datapath.
package fuzz_top_pkg;

  localparam int unsigned A_W     = 17;
  localparam int unsigned B_W     = 22;
  localparam int unsigned C_W     = 21;
  localparam int unsigned D_W     = 18;
  localparam int unsigned IN_W    = A_W + B_W + C_W + D_W;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned FLAGS_W = 8;
  localparam int unsigned POP_W   = 7;
  localparam int unsigned MAX_W   = 22;
  localparam int unsigned SHR_W   = 21;
  localparam int unsigned ROT_W   = 22;
  localparam int unsigned XOR_W   = 21;
  localparam int unsigned SUM_W   = 23;
  localparam int unsigned DIFF_W  = 23;
  localparam int unsigned PROD_W  = 33;
  localparam int unsigned SPROD_W = 30;
  localparam int unsigned ACC_W   = 64;
  localparam int unsigned ACC_SUM_W = ACC_W + 1;

  // LSB offsets of every field inside y
  localparam int unsigned CNT_LSB    = 0;
  localparam int unsigned FLAGS_LSB  = CNT_LSB   + CNT_W;
  localparam int unsigned POP_LSB    = FLAGS_LSB + FLAGS_W;
  localparam int unsigned MAX_LSB    = POP_LSB   + POP_W;
  localparam int unsigned SHR_LSB    = MAX_LSB   + MAX_W;
  localparam int unsigned ROT_LSB    = SHR_LSB   + SHR_W;
  localparam int unsigned XOR_LSB    = ROT_LSB   + ROT_W;
  localparam int unsigned SUM_LSB    = XOR_LSB   + XOR_W;
  localparam int unsigned DIFF_LSB   = SUM_LSB   + SUM_W;
  localparam int unsigned PROD_LSB   = DIFF_LSB  + DIFF_W;
  localparam int unsigned SPROD_LSB  = PROD_LSB  + PROD_W;
  localparam int unsigned ACC_LSB    = SPROD_LSB + SPROD_W;
  localparam int unsigned RIN_LSB    = ACC_LSB   + ACC_W;
  localparam int unsigned RHIST_LSB  = RIN_LSB   + IN_W;
  localparam int unsigned Y_W        = RHIST_LSB + IN_W;

  typedef struct packed {
    logic [D_W-1:0] d;
    logic [C_W-1:0] c;
    logic [B_W-1:0] b;
    logic [A_W-1:0] a;
  } in_t;

  typedef struct packed {
    logic b_lt_d;
    logic a_eq_c;
    logic a_all;
    logic b_any;
    logic c_par;
    logic d_par;
    logic d_sign;
    logic b_sign;
  } flags_t;

  // Packed image of y, MSB field first
  typedef struct packed {
    in_t                r_hist;
    in_t                r_in;
    logic [ACC_W-1:0]   acc;
    logic [SPROD_W-1:0] sprod;
    logic [PROD_W-1:0]  prod;
    logic [DIFF_W-1:0]  diff;
    logic [SUM_W-1:0]   sum;
    logic [XOR_W-1:0]   xr;
    logic [ROT_W-1:0]   rot;
    logic [SHR_W-1:0]   shr;
    logic [MAX_W-1:0]   max;
    logic [POP_W-1:0]   pop;
    flags_t             flags;
    logic [CNT_W-1:0]   cnt;
  } y_t;

  // Rotate left within B_W bits by a 3-bit amount
  function automatic logic [B_W-1:0] rotl_b(input logic [B_W-1:0] v, input logic [2:0] k);
    logic [2*B_W-1:0] t;
    t = {v, v} << k;
    return t[2*B_W-1:B_W];
  endfunction

endpackage

// File: rtl/fuzz_popcount.sv
// Combinational population count over the 78-bit concatenated input word.
module fuzz_popcount
  import fuzz_top_pkg::*;
(
  input  logic [IN_W-1:0]  vec,
  output logic [POP_W-1:0] count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      count_c = count_c + POP_W'(vec[i]);
    end
  end

endmodule

// File: rtl/fuzz_top.sv
// Registered mixing datapath: four mixed-sign operands into a 446-bit observation vector.
// Define ACC_SAT_EN to make the 64-bit accumulator saturate instead of wrapping.
module fuzz_top
  import fuzz_top_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [A_W-1:0] wire0,
  input  logic [B_W-1:0] wire1,
  input  logic [C_W-1:0] wire2,
  input  logic [D_W-1:0] wire3,
  output logic [Y_W-1:0] y
);

  y_t                 y_q;
  in_t                in_c;
  logic [POP_W-1:0]   pop_c;
  logic [B_W-1:0]     d_ext_c;
  logic               b_lt_d_c;
  logic [SUM_W-1:0]   b23_c;
  logic [SUM_W-1:0]   d23_c;
  logic [SPROD_W-1:0] b30_c;
  logic [SPROD_W-1:0] d30_c;
  logic [ACC_W-1:0]   acc_next_c;

  assign in_c = {wire3, wire2, wire1, wire0};

  fuzz_popcount u_popcount (
    .vec     (in_c),
    .count_c (pop_c)
  );

  // Sign extensions feeding compare, add/sub and the signed multiply
  assign d_ext_c  = {{(B_W-D_W){wire3[D_W-1]}}, wire3};
  assign b_lt_d_c = $signed(wire1) < $signed(d_ext_c);
  assign b23_c    = {{(SUM_W-B_W){wire1[B_W-1]}}, wire1};
  assign d23_c    = {{(SUM_W-D_W){wire3[D_W-1]}}, wire3};
  assign b30_c    = {{(SPROD_W-12){wire1[11]}}, wire1[11:0]};
  assign d30_c    = {{(SPROD_W-D_W){wire3[D_W-1]}}, wire3};

`ifdef ACC_SAT_EN
  logic [ACC_SUM_W-1:0] acc_sum_c;
  assign acc_sum_c  = {1'b0, y_q.acc} + ACC_SUM_W'(y_q.prod);
  assign acc_next_c = acc_sum_c[ACC_W] ? '1 : acc_sum_c[ACC_W-1:0];
`else
  assign acc_next_c = y_q.acc + ACC_W'(y_q.prod);
`endif

  // Every y bit is a flop; acc and r_hist consume stage-1 flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q.cnt    <= y_q.cnt + CNT_W'(1);
      y_q.flags  <= {b_lt_d_c, wire0 == wire2[A_W-1:0], &wire0, |wire1,
                     ^wire2, ^wire3, wire3[D_W-1], wire1[B_W-1]};
      y_q.pop    <= pop_c;
      y_q.max    <= b_lt_d_c ? d_ext_c : wire1;
      y_q.shr    <= wire2 >> wire3[3:0];
      y_q.rot    <= rotl_b(wire1, wire0[2:0]);
      y_q.xr     <= wire2 ^ C_W'(wire0);
      y_q.sum    <= b23_c + d23_c;
      y_q.diff   <= b23_c - d23_c;
      y_q.prod   <= PROD_W'(wire0) * PROD_W'(wire2[15:0]);
      y_q.sprod  <= d30_c * b30_c;
      y_q.acc    <= acc_next_c;
      y_q.r_in   <= in_c;
      y_q.r_hist <= y_q.r_in;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_fuzz_top.sv
// Self-checking bench for fuzz_top: directed and random operands against an arithmetic reference model.
module tb_fuzz_top;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [16:0]  wire0 = '0;
  logic [21:0]  wire1 = '0;
  logic [20:0]  wire2 = '0;
  logic [17:0]  wire3 = '0;
  logic [445:0] y;

  always #5 clk = ~clk;

  fuzz_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wire0 (wire0),
    .wire1 (wire1),
    .wire2 (wire2),
    .wire3 (wire3),
    .y     (y)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int           m_cnt;
  logic [63:0]  m_acc;
  logic [32:0]  m_prod_prev;
  logic [77:0]  m_rin_prev;
  logic [77:0]  m_hist;
  logic [7:0]   e_flags;
  logic [6:0]   e_pop;
  logic [21:0]  e_max;
  logic [20:0]  e_shr;
  logic [21:0]  e_rot;
  logic [20:0]  e_xr;
  logic [22:0]  e_sum;
  logic [22:0]  e_diff;
  logic [32:0]  e_prod;
  logic [29:0]  e_sprod;
  logic [77:0]  e_rin;

  function automatic int sx(input logic [31:0] v, input int w);
    int r;
    r = int'(v);
    if (v[w-1]) r = r - (1 << w);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    n_assert++;
    assert (y === '0) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=0", tag, y);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_acc = '0; m_prod_prev = '0; m_rin_prev = '0; m_hist = '0;
  endtask

  // One rising edge worth of behaviour, from the field definitions
  task automatic model_edge(input logic [16:0] a, input logic [21:0] b,
                            input logic [20:0] c, input logic [17:0] d);
    int sb, sd, sb12, mx, k;
    longint unsigned r;
    sb   = sx(32'(b), 22);
    sd   = sx(32'(d), 18);
    sb12 = sx(32'(b[11:0]), 12);
    m_cnt = (m_cnt + 1) % 65536;
`ifdef ACC_SAT_EN
    if (m_acc > 64'hFFFF_FFFF_FFFF_FFFF - 64'(m_prod_prev)) m_acc = '1;
    else m_acc = m_acc + 64'(m_prod_prev);
`else
    m_acc = m_acc + 64'(m_prod_prev);
`endif
    m_hist  = m_rin_prev;
    e_flags = {sb < sd, a == c[16:0], a == 17'h1FFFF, b != '0,
               ($countones(c) % 2) == 1, ($countones(d) % 2) == 1, sd < 0, sb < 0};
    e_pop   = 7'($countones({d, c, b, a}));
    mx      = (sb > sd) ? sb : sd;
    e_max   = 22'(mx);
    e_shr   = 21'(int'(c) / (1 << int'(d[3:0])));
    k       = int'(a[2:0]);
    r       = (64'(b) << k) | (64'(b) >> (22 - k));
    e_rot   = 22'(r);
    e_xr    = c ^ 21'(a);
    e_sum   = 23'(sb + sd);
    e_diff  = 23'(sb - sd);
    e_prod  = 33'(64'(a) * 64'(c[15:0]));
    e_sprod = 30'(sd * sb12);
    e_rin   = {d, c, b, a};
    m_prod_prev = e_prod;
    m_rin_prev  = e_rin;
  endtask

  task automatic check_all();
    chk("cnt",    128'(y[15:0]),    128'(m_cnt[15:0]));
    chk("flags",  128'(y[23:16]),   128'(e_flags));
    chk("pop",    128'(y[30:24]),   128'(e_pop));
    chk("max",    128'(y[52:31]),   128'(e_max));
    chk("shr",    128'(y[73:53]),   128'(e_shr));
    chk("rot",    128'(y[95:74]),   128'(e_rot));
    chk("xor",    128'(y[116:96]),  128'(e_xr));
    chk("sum",    128'(y[139:117]), 128'(e_sum));
    chk("diff",   128'(y[162:140]), 128'(e_diff));
    chk("prod",   128'(y[195:163]), 128'(e_prod));
    chk("sprod",  128'(y[225:196]), 128'(e_sprod));
    chk("acc",    128'(y[289:226]), 128'(m_acc));
    chk("r_in",   128'(y[367:290]), 128'(e_rin));
    chk("r_hist", 128'(y[445:368]), 128'(m_hist));
  endtask

  // Drive at the falling edge, sample 1 ns after the rising edge
  task automatic step(input logic [16:0] a, input logic [21:0] b,
                      input logic [20:0] c, input logic [17:0] d, input bit chk_en);
    @(negedge clk);
    wire0 = a; wire1 = b; wire2 = c; wire3 = d;
    @(posedge clk);
    #1;
    model_edge(a, b, c, d);
    if (chk_en) check_all();
  endtask

  task automatic rand_step(input bit chk_en);
    step(17'($urandom), 22'($urandom), 21'($urandom), 18'($urandom), chk_en);
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    wire0 = 17'($urandom); wire1 = 22'($urandom); wire2 = 21'($urandom); wire3 = 18'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk_zero(tag);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    reset_dut("reset_hold");

    // Counter start-up after release
    rand_step(1'b1); chk("cnt_first",  128'(y[15:0]), 128'(16'd1));
    rand_step(1'b1); chk("cnt_second", 128'(y[15:0]), 128'(16'd2));
    rand_step(1'b1); chk("cnt_third",  128'(y[15:0]), 128'(16'd3));

    // Product and accumulator latency
    reset_dut("reset_arith");
    step(17'd3, 22'd0, 21'd5, 18'd0, 1'b1);
    chk("arith_prod", 128'(y[195:163]), 128'(33'd15));
    chk("arith_acc0", 128'(y[289:226]), 128'(64'd0));
    step(17'd3, 22'd0, 21'd5, 18'd0, 1'b1);
    chk("arith_acc1", 128'(y[289:226]), 128'(64'd15));
    step(17'd3, 22'd0, 21'd5, 18'd0, 1'b1);
    chk("arith_acc2", 128'(y[289:226]), 128'(64'd30));

    // Signed corner: B = -1, D = 1
    step(17'd0, 22'h3FFFFF, 21'd0, 18'd1, 1'b1);
    chk("signed_sum",  128'(y[139:117]), 128'(23'h000000));
    chk("signed_diff", 128'(y[162:140]), 128'(23'h7FFFFE));
    chk("signed_max",  128'(y[52:31]),   128'(22'd1));
    chk("signed_lt",   128'(y[23]),      128'(1'b1));

    // Shift and rotate
    step(17'd3, 22'd1, 21'h100000, 18'd4, 1'b1);
    chk("rot_val", 128'(y[95:74]), 128'(22'd8));
    chk("shr_val", 128'(y[73:53]), 128'(21'h010000));

    // Extreme operands
    step(17'h1FFFF, 22'h200000, 21'h1FFFFF, 18'h20000, 1'b1);
    step(17'h1FFFF, 22'h1FFFFF, 21'h01FFFF, 18'h1FFFF, 1'b1);

    repeat (300) rand_step(1'b1);

    // Asynchronous reset pulse between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    rst_n = 1'b1;
    repeat (20) rand_step(1'b1);

    // Counter wrap after 65536 edges
    reset_dut("reset_wrap");
    repeat (65535) rand_step(1'b0);
    rand_step(1'b1);
    chk("cnt_wrap", 128'(y[15:0]), 128'(16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
